// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect definitions: bus widths, FSM state encoding
// and the default five-slave address map (memory, mtime, unused, uart, loader).
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DERR  = 2'd3
  } wb_state_e;

  localparam logic [31:0] MEM_BASE    = 32'h0000_0000;
  localparam logic [31:0] MEM_MASK    = 32'hFFFF_8000;
  localparam logic [31:0] MTIME_BASE  = 32'h0000_8000;
  localparam logic [31:0] MTIME_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] UART_BASE   = 32'h0000_8010;
  localparam logic [31:0] UART_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] LOADER_BASE = 32'h0000_8014;
  localparam logic [31:0] LOADER_MASK = 32'hFFFF_FFFF;

  // Slot 2 is an unused spare entry that can never decode: (adr & 0) is never 1.
  localparam logic [31:0] SPARE_BASE  = 32'h0000_0001;
  localparam logic [31:0] SPARE_MASK  = 32'h0000_0000;

  localparam logic [5*32-1:0] WB_DEFAULT_BASE =
    {LOADER_BASE, UART_BASE, SPARE_BASE, MTIME_BASE, MEM_BASE};
  localparam logic [5*32-1:0] WB_DEFAULT_MASK =
    {LOADER_MASK, UART_MASK, SPARE_MASK, MTIME_MASK, MEM_MASK};

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: searches from the master after the last grant and
// only moves its pointer when the interconnect commits a grant.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   advance_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]       gnt_idx_o
);

  logic [IDX_W-1:0] lastGrant_q;
  logic             found;
  int               cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = lastGrant_q;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = int'(lastGrant_q) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = IDX_W'(cand);
      end
    end
  end

  // Reset points at the last master so master 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lastGrant_q <= IDX_W'(NUM_MASTERS - 1);
    end else if (advance_i) begin
      lastGrant_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Shared-bus Wishbone pipelined interconnect: N masters arbitrated round-robin,
// one outstanding transaction, address-decoded slaves, decode error and watchdog.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter int                          NUM_MASTERS    = 2,
  parameter int                          NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK     = '0,
  parameter int                          TIMEOUT_CYCLES = 255
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
  input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
  input  logic [NUM_MASTERS*WB_SEL_W-1:0] m_sel_i,
  output logic [NUM_MASTERS-1:0]          m_stall_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_o,
  output logic [NUM_SLAVES-1:0]           s_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_stb_o,
  output logic                            s_we_o,
  output logic [WB_ADR_W-1:0]             s_adr_o,
  output logic [WB_DAT_W-1:0]             s_dat_o,
  output logic [WB_SEL_W-1:0]             s_sel_o,
  input  logic [NUM_SLAVES-1:0]           s_stall_i,
  input  logic [NUM_SLAVES-1:0]           s_ack_i,
  input  logic [NUM_SLAVES-1:0]           s_err_i,
  input  logic [NUM_SLAVES*WB_DAT_W-1:0]  s_dat_i,
  output logic                            timeout_o
);

  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  wb_state_e         state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [SIDX_W-1:0] sidx_q, sidx_d;
  logic [15:0]       wdog_q, wdog_d;

  logic [NUM_MASTERS-1:0] arbGnt;
  logic [IDX_W-1:0]       arbIdx;
  logic                   arbAdv;

  int                gi;
  int                si;
  logic              gCyc;
  logic              gStb;
  logic [31:0]       gAdr;
  logic              hit;
  logic [SIDX_W-1:0] hitIdx;

  wb_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .req_i     (m_cyc_i),
    .advance_i (arbAdv),
    .gnt_o     (arbGnt),
    .gnt_idx_o (arbIdx)
  );

  assign gi   = int'(gnt_q);
  assign si   = int'(sidx_q);
  assign gCyc = m_cyc_i[gi];
  assign gStb = m_stb_i[gi] & m_cyc_i[gi];
  assign gAdr = m_adr_i[gi*WB_ADR_W +: WB_ADR_W];

  // Walk downwards so the lowest matching slave index is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((gAdr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit    = 1'b1;
        hitIdx = SIDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sidx_d    = sidx_q;
    wdog_d    = wdog_q;
    arbAdv    = 1'b0;
    s_cyc_o   = '0;
    s_stb_o   = '0;
    s_we_o    = m_we_i[gi];
    s_adr_o   = gAdr;
    s_dat_o   = m_dat_i[gi*WB_DAT_W +: WB_DAT_W];
    s_sel_o   = m_sel_i[gi*WB_SEL_W +: WB_SEL_W];
    m_stall_o = m_stb_i;
    m_ack_o   = '0;
    m_err_o   = '0;
    m_dat_o   = '0;
    timeout_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (|arbGnt) begin
          gnt_d   = arbIdx;
          arbAdv  = 1'b1;
          state_d = GRANT;
        end
      end

      GRANT: begin
        s_cyc_o = {NUM_SLAVES{gCyc}};
        if (!gCyc) begin
          state_d = IDLE;
        end else if (hit) begin
          s_stb_o[hitIdx] = gStb;
          m_stall_o[gi]   = s_stall_i[hitIdx];
          if (gStb && !s_stall_i[hitIdx]) begin
            sidx_d  = hitIdx;
            wdog_d  = '0;
            state_d = WAIT;
          end
        end else begin
          m_stall_o[gi] = 1'b0;
          if (gStb) state_d = DERR;
        end
      end

      // Response path is combinational; an ack arriving on the expiry cycle wins.
      WAIT: begin
        s_cyc_o       = {NUM_SLAVES{gCyc}};
        m_stall_o[gi] = 1'b1;
        if (!gCyc) begin
          state_d = IDLE;
        end else if (s_ack_i[si] || s_err_i[si]) begin
          m_ack_o[gi]                      = s_ack_i[si];
          m_err_o[gi]                      = s_err_i[si];
          m_dat_o[gi*WB_DAT_W +: WB_DAT_W] = s_dat_i[si*WB_DAT_W +: WB_DAT_W];
          state_d                          = GRANT;
        end else if (wdog_q == WDOG_LAST) begin
          m_err_o[gi] = 1'b1;
          timeout_o   = 1'b1;
          wdog_d      = '0;
          state_d     = GRANT;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      DERR: begin
        s_cyc_o       = {NUM_SLAVES{gCyc}};
        m_stall_o[gi] = 1'b1;
        if (!gCyc) begin
          state_d = IDLE;
        end else begin
          m_err_o[gi] = 1'b1;
          state_d     = GRANT;
        end
      end

      default: state_d = IDLE;
    endcase

    // Keep the bus quiet while reset is held, whatever state it interrupted.
    if (wb_rst_i) begin
      s_cyc_o   = '0;
      s_stb_o   = '0;
      m_ack_o   = '0;
      m_err_o   = '0;
      m_dat_o   = '0;
      timeout_o = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sidx_q  <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sidx_q  <= sidx_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: arbitration order, uart read, decode
// error, watchdog expiry with a late ack, master abort and reset mid-WAIT.
module tb_wb_interconnect;
  import wb_pkg::*;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [63:0]   m_adr, m_dat;
  logic [7:0]    m_sel;
  logic [1:0]    m_stall, m_ack, m_err;
  logic [63:0]   m_dat_out;
  logic [4:0]    s_cyc, s_stb;
  logic          s_we;
  logic [31:0]   s_adr, s_dat;
  logic [3:0]    s_sel;
  logic [4:0]    s_stall, s_ack, s_err;
  logic [159:0]  s_dat_in;
  logic          timeout;

  int testCount = 0;
  int failCount = 0;

  always #5 wb_clk = ~wb_clk;

  wb_interconnect #(
    .NUM_MASTERS    (2),
    .NUM_SLAVES     (5),
    .SLAVE_BASE     (WB_DEFAULT_BASE),
    .SLAVE_MASK     (WB_DEFAULT_MASK),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i  (wb_clk),
    .wb_rst_i  (wb_rst),
    .m_cyc_i   (m_cyc),
    .m_stb_i   (m_stb),
    .m_we_i    (m_we),
    .m_adr_i   (m_adr),
    .m_dat_i   (m_dat),
    .m_sel_i   (m_sel),
    .m_stall_o (m_stall),
    .m_ack_o   (m_ack),
    .m_err_o   (m_err),
    .m_dat_o   (m_dat_out),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dat),
    .s_sel_o   (s_sel),
    .s_stall_i (s_stall),
    .s_ack_i   (s_ack),
    .s_err_i   (s_err),
    .s_dat_i   (s_dat_in),
    .timeout_o (timeout)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cyc, input logic [1:0] stb,
                               input logic [31:0] adr0);
    m_cyc       = cyc;
    m_stb       = stb;
    m_adr[31:0] = adr0;
  endtask

  task automatic nextCycle();
    @(posedge wb_clk);
    #1;
  endtask

  initial begin
    wb_rst   = 1'b1;
    m_we     = '0;
    m_dat    = {32'hAAAA_0001, 32'h5555_0000};
    m_sel    = 8'hFF;
    m_adr    = {32'h0000_8014, 32'h0000_8010};
    s_stall  = '0;
    s_ack    = '0;
    s_err    = '0;
    s_dat_in = '0;
    s_dat_in[3*32 +: 32] = 32'hDEAD_BEEF;
    applyStimulus(2'b11, 2'b00, 32'h0000_8010);

    // Reset with both masters requesting
    nextCycle();
    nextCycle();
    #1;
    checkOutput("rst_state", 64'(dut.state_q), 64'(IDLE));
    checkOutput("rst_s_cyc", 64'(s_cyc), 64'h0);
    checkOutput("rst_ack_err_to", 64'({m_ack, m_err, timeout}), 64'h0);

    wb_rst = 1'b0;
    #1;
    checkOutput("arb_cycle_s_cyc", 64'(s_cyc), 64'h0);
    nextCycle();
    #1;
    checkOutput("m0_grant_s_cyc", 64'(s_cyc), 64'h1F);
    checkOutput("m0_grant_adr", 64'(s_adr), 64'h0000_8010);

    applyStimulus(2'b10, 2'b00, 32'h0000_8010);
    #1;
    checkOutput("m0_drop_s_cyc", 64'(s_cyc), 64'h0);
    nextCycle();
    #1;
    checkOutput("idle_rearb_s_cyc", 64'(s_cyc), 64'h0);
    nextCycle();
    #1;
    checkOutput("m1_grant_s_cyc", 64'(s_cyc), 64'h1F);
    checkOutput("m1_grant_adr", 64'(s_adr), 64'h0000_8014);

    applyStimulus(2'b00, 2'b00, 32'h0000_8010);
    nextCycle();

    // Uart read by master 0, ack two cycles after stb
    applyStimulus(2'b01, 2'b01, 32'h0000_8010);
    #1;
    checkOutput("idle_stall_eq_stb", 64'(m_stall), 64'h1);
    nextCycle();
    #1;
    checkOutput("uart_s_stb", 64'(s_stb), 64'h08);
    checkOutput("uart_accept_stall", 64'(m_stall), 64'h0);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 32'h0000_8010);
    #1;
    checkOutput("wait_stall", 64'(m_stall), 64'h1);
    checkOutput("wait_s_stb", 64'(s_stb), 64'h0);
    checkOutput("wait_no_ack", 64'(m_ack), 64'h0);
    nextCycle();
    s_ack = 5'b01000;
    #1;
    checkOutput("uart_ack", 64'(m_ack), 64'h1);
    checkOutput("uart_data", m_dat_out, 64'h0000_0000_DEAD_BEEF);
    nextCycle();
    s_ack = '0;

    // Decode miss; master 1 strobes while ungranted
    applyStimulus(2'b01, 2'b11, 32'h0001_0000);
    #1;
    checkOutput("ack_after_return", 64'(m_ack), 64'h0);
    checkOutput("miss_s_stb", 64'(s_stb), 64'h0);
    checkOutput("miss_no_err_yet", 64'(m_err), 64'h0);
    checkOutput("miss_stall", 64'(m_stall), 64'h2);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 32'h0001_0000);
    #1;
    checkOutput("derr_err", 64'(m_err), 64'h1);
    checkOutput("derr_s_stb", 64'(s_stb), 64'h0);
    nextCycle();
    #1;
    checkOutput("derr_one_cycle", 64'(m_err), 64'h0);

    // Watchdog: mtime stalls one cycle, then never responds
    applyStimulus(2'b01, 2'b01, 32'h0000_8000);
    s_stall = 5'b00010;
    #1;
    checkOutput("slave_stall", 64'(m_stall), 64'h1);
    checkOutput("mtime_s_stb", 64'(s_stb), 64'h02);
    nextCycle();
    s_stall = '0;
    #1;
    checkOutput("stall_release", 64'(m_stall), 64'h0);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 32'h0000_8000);
    for (int k = 1; k <= 7; k++) begin
      #1;
      checkOutput($sformatf("wdog_quiet_%0d", k), 64'({m_err, timeout}), 64'h0);
      nextCycle();
    end
    #1;
    checkOutput("timeout_err", 64'(m_err), 64'h1);
    checkOutput("timeout_pulse", 64'(timeout), 64'h1);
    nextCycle();
    s_ack = 5'b00010;
    #1;
    checkOutput("late_ack_blocked", 64'(m_ack), 64'h0);
    checkOutput("timeout_one_cycle", 64'(timeout), 64'h0);
    nextCycle();
    s_ack = '0;

    // Master abort while waiting on uart
    applyStimulus(2'b01, 2'b01, 32'h0000_8010);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 32'h0000_8010);
    s_ack = 5'b01000;
    #1;
    checkOutput("abort_no_ack", 64'(m_ack), 64'h0);
    checkOutput("abort_s_cyc", 64'(s_cyc), 64'h0);
    nextCycle();
    s_ack = '0;
    #1;
    checkOutput("abort_idle", 64'(dut.state_q), 64'(IDLE));
    checkOutput("abort_s_cyc_next", 64'(s_cyc), 64'h0);

    // Reset asserted mid-WAIT with the slave acking
    applyStimulus(2'b01, 2'b01, 32'h0000_8010);
    nextCycle();
    nextCycle();
    applyStimulus(2'b01, 2'b00, 32'h0000_8010);
    #1;
    checkOutput("pre_rst_wait", 64'(dut.state_q), 64'(WAIT));
    wb_rst = 1'b1;
    s_ack  = 5'b01000;
    #1;
    checkOutput("rst_wait_no_ack", 64'(m_ack), 64'h0);
    checkOutput("rst_wait_s_cyc", 64'(s_cyc), 64'h0);
    nextCycle();
    #1;
    checkOutput("rst_wait_idle", 64'(dut.state_q), 64'(IDLE));
    checkOutput("rst_wait_ack_held", 64'(m_ack), 64'h0);
    wb_rst = 1'b0;
    s_ack  = '0;
    applyStimulus(2'b00, 2'b00, 32'h0000_0000);
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
